pc_unit: RTL and testbench

- Program-counter datapath stage directly downstream of the PC control decoder.
- Holds the 16-bit PC as PCL and PCH registers, each with an input-select latch (PCLS, PCHS), and a ripple incrementer that carries from PCL into PCH.
- Consumes the decoder's load, hold and drive strobes. Drives PC bytes onto the internal DB, ADL and ADH buses.
- Single-clock model: one PHI0 rising edge equals one CPU cycle.

---
 rtl/pc_unit_if.sv | 37 +++
 rtl/pc_unit.sv | 70 +++++++
 tb/tb_pc_unit.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/pc_unit_if.sv
// Strobe and bus bundle between the PC control decoder (master) and the PC datapath (slave).
interface pc_unit_if;
    logic        n_ready;
    logic        n_IPC;
    logic        PCL_PCL;
    logic        ADL_PCL;
    logic        PCH_PCH;
    logic        ADH_PCH;
    logic        DL_PCH;
    logic        PCL_DB;
    logic        PCH_DB;
    logic        PCL_ADL;
    logic        PCH_ADH;
    logic [7:0]  ADL_in;
    logic [7:0]  ADH_in;
    logic [7:0]  DL_in;
    logic [7:0]  DB_out;
    logic        DB_drv;
    logic [7:0]  ADL_out;
    logic        ADL_drv;
    logic [7:0]  ADH_out;
    logic        ADH_drv;
    logic [15:0] PC;
    logic        PCLC;

    modport master (
        output n_ready, n_IPC, PCL_PCL, ADL_PCL, PCH_PCH, ADH_PCH, DL_PCH,
               PCL_DB, PCH_DB, PCL_ADL, PCH_ADH, ADL_in, ADH_in, DL_in,
        input  DB_out, DB_drv, ADL_out, ADL_drv, ADH_out, ADH_drv, PC, PCLC
    );

    modport slave (
        input  n_ready, n_IPC, PCL_PCL, ADL_PCL, PCH_PCH, ADH_PCH, DL_PCH,
               PCL_DB, PCH_DB, PCL_ADL, PCH_ADH, ADL_in, ADH_in, DL_in,
        output DB_out, DB_drv, ADL_out, ADL_drv, ADH_out, ADH_drv, PC, PCLC
    );
endinterface

// File: rtl/pc_unit.sv
// Program-counter datapath: PCL/PCH with input-select latches, ripple incrementer
// and precharged-bus drive model (undriven bus reads FF, multiple drivers wired-AND).
module pc_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic    PHI0,
    input  logic    n_RES,
    pc_unit_if.slave bus
);
    logic [7:0] pcl, pch, pcls, pchs;
    logic       pclc;
    logic [7:0] pcls_next, pchs_next, pcl_next, pch_next;
    logic       cl;
    logic       inc;

    always_comb begin
        case ({bus.ADL_PCL, bus.PCL_PCL})
            2'b11:   pcls_next = bus.ADL_in & pcl;
            2'b10:   pcls_next = bus.ADL_in;
            2'b01:   pcls_next = pcl;
            default: pcls_next = pcls;
        endcase
    end

    // Each asserted source pulls bits low; with no source the latch keeps its value.
    always_comb begin
        pchs_next = 8'hFF;
        if (bus.ADH_PCH) pchs_next = pchs_next & bus.ADH_in;
        if (bus.DL_PCH)  pchs_next = pchs_next & bus.DL_in;
        if (bus.PCH_PCH) pchs_next = pchs_next & pch;
        if (!(bus.ADH_PCH || bus.DL_PCH || bus.PCH_PCH)) pchs_next = pchs;
    end

    assign inc             = ~bus.n_IPC;
    assign {cl, pcl_next}  = {1'b0, pcls_next} + {8'h00, inc};
    assign pch_next        = pchs_next + {7'b0, cl};

    always_ff @(posedge PHI0 or negedge n_RES) begin
        if (!n_RES) begin
            pcl  <= RESET_PC[7:0];
            pch  <= RESET_PC[15:8];
            pcls <= RESET_PC[7:0];
            pchs <= RESET_PC[15:8];
            pclc <= 1'b0;
        end else if (!bus.n_ready) begin
            pcl  <= pcl_next;
            pch  <= pch_next;
            pcls <= pcls_next;
            pchs <= pchs_next;
            pclc <= cl;
        end
    end

    always_comb begin
        case ({bus.PCH_DB, bus.PCL_DB})
            2'b11:   bus.DB_out = pcl & pch;
            2'b01:   bus.DB_out = pcl;
            2'b10:   bus.DB_out = pch;
            default: bus.DB_out = 8'hFF;
        endcase
        bus.DB_drv  = bus.PCL_DB | bus.PCH_DB;
        bus.ADL_drv = bus.PCL_ADL;
        bus.ADL_out = bus.PCL_ADL ? pcl : 8'hFF;
        bus.ADH_drv = bus.PCH_ADH;
        bus.ADH_out = bus.PCH_ADH ? pch : 8'hFF;
    end

    assign bus.PC   = {pch, pcl};
    assign bus.PCLC = pclc;
endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset, increment, jump load, stall, bus drives, hold and wired-AND.
module tb_pc_unit;
    logic PHI0 = 1'b0;
    logic n_RES = 1'b0;
    int   errors = 0;
    int   checks = 0;

    pc_unit_if bus ();

    pc_unit #(.RESET_PC(16'h0000)) dut (
        .PHI0  (PHI0),
        .n_RES (n_RES),
        .bus   (bus.slave)
    );

    always #5 PHI0 = ~PHI0;

    task automatic clear_strobes();
        bus.n_ready = 1'b0;
        bus.n_IPC   = 1'b1;
        bus.PCL_PCL = 1'b0;
        bus.ADL_PCL = 1'b0;
        bus.PCH_PCH = 1'b0;
        bus.ADH_PCH = 1'b0;
        bus.DL_PCH  = 1'b0;
        bus.PCL_DB  = 1'b0;
        bus.PCH_DB  = 1'b0;
        bus.PCL_ADL = 1'b0;
        bus.PCH_ADH = 1'b0;
        bus.ADL_in  = 8'h00;
        bus.ADH_in  = 8'h00;
        bus.DL_in   = 8'h00;
    endtask

    task automatic step();
        @(posedge PHI0);
        #1;
    endtask

    task automatic load(input logic [7:0] hi, input logic [7:0] lo);
        clear_strobes();
        bus.ADL_PCL = 1'b1;
        bus.ADH_PCH = 1'b1;
        bus.ADL_in  = lo;
        bus.ADH_in  = hi;
        step();
        clear_strobes();
    endtask

    task automatic test_reset();
        clear_strobes();
        n_RES = 1'b0;
        #2;
        checks++;
        if (bus.PC !== 16'h0000) begin errors++; $display("FAIL reset_pc got=%h exp=0000", bus.PC); end
        checks++;
        if (bus.PCLC !== 1'b0) begin errors++; $display("FAIL reset_pclc got=%b exp=0", bus.PCLC); end
        checks++;
        if ({bus.DB_drv, bus.ADL_drv, bus.ADH_drv} !== 3'b000) begin
            errors++; $display("FAIL reset_drv got=%b exp=000", {bus.DB_drv, bus.ADL_drv, bus.ADH_drv});
        end
        checks++;
        if (bus.DB_out !== 8'hFF) begin errors++; $display("FAIL reset_db got=%h exp=FF", bus.DB_out); end
        @(negedge PHI0);
        n_RES = 1'b1;
        bus.PCL_PCL = 1'b1;
        bus.PCH_PCH = 1'b1;
        bus.n_IPC   = 1'b0;
        step();
        step();
        checks++;
        if (bus.PC !== 16'h0002) begin errors++; $display("FAIL reset_run got=%h exp=0002", bus.PC); end
        #2;
        n_RES = 1'b0;
        #1;
        checks++;
        if (bus.PC !== 16'h0000) begin errors++; $display("FAIL reset_async got=%h exp=0000", bus.PC); end
        @(negedge PHI0);
        n_RES = 1'b1;
        clear_strobes();
    endtask

    task automatic test_increment();
        logic [15:0] exp_pc [3] = '{16'h00FF, 16'h0100, 16'h0101};
        logic        exp_c  [3] = '{1'b0, 1'b1, 1'b0};
        load(8'h00, 8'hFE);
        checks++;
        if (bus.PC !== 16'h00FE) begin errors++; $display("FAIL inc_load got=%h exp=00FE", bus.PC); end
        bus.PCL_PCL = 1'b1;
        bus.PCH_PCH = 1'b1;
        bus.n_IPC   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.PC !== exp_pc[i] || bus.PCLC !== exp_c[i]) begin
                errors++; $display("FAIL inc_run[%0d] got=%h/%b exp=%h/%b", i, bus.PC, bus.PCLC, exp_pc[i], exp_c[i]);
            end
        end
        load(8'hFF, 8'hFF);
        bus.PCL_PCL = 1'b1;
        bus.PCH_PCH = 1'b1;
        bus.n_IPC   = 1'b0;
        step();
        checks++;
        if (bus.PC !== 16'h0000 || bus.PCLC !== 1'b1) begin
            errors++; $display("FAIL inc_wrap got=%h/%b exp=0000/1", bus.PC, bus.PCLC);
        end
        clear_strobes();
    endtask

    task automatic test_jump();
        bus.ADL_PCL = 1'b1;
        bus.ADH_PCH = 1'b1;
        bus.ADL_in  = 8'h34;
        bus.ADH_in  = 8'h12;
        bus.n_IPC   = 1'b1;
        step();
        checks++;
        if (bus.PC !== 16'h1234) begin errors++; $display("FAIL jump_plain got=%h exp=1234", bus.PC); end
        bus.n_IPC = 1'b0;
        step();
        checks++;
        if (bus.PC !== 16'h1235) begin errors++; $display("FAIL jump_inc got=%h exp=1235", bus.PC); end
        bus.ADL_in = 8'hFF;
        step();
        checks++;
        if (bus.PC !== 16'h1300 || bus.PCLC !== 1'b1) begin
            errors++; $display("FAIL jump_carry got=%h/%b exp=1300/1", bus.PC, bus.PCLC);
        end
        clear_strobes();
    endtask

    task automatic test_stall();
        load(8'h20, 8'h00);
        bus.n_ready = 1'b1;
        bus.ADL_PCL = 1'b1;
        bus.ADL_in  = 8'h55;
        bus.n_IPC   = 1'b0;
        bus.PCL_ADL = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (bus.PC !== 16'h2000) begin errors++; $display("FAIL stall_hold[%0d] got=%h exp=2000", i, bus.PC); end
        end
        checks++;
        if (bus.ADL_out !== 8'h00 || bus.ADL_drv !== 1'b1) begin
            errors++; $display("FAIL stall_drive got=%h/%b exp=00/1", bus.ADL_out, bus.ADL_drv);
        end
        bus.n_ready = 1'b0;
        step();
        checks++;
        if (bus.PC !== 16'h2056) begin errors++; $display("FAIL stall_release got=%h exp=2056", bus.PC); end
        clear_strobes();
    endtask

    task automatic test_bus();
        load(8'hA5, 8'h5A);
        bus.PCL_DB = 1'b1;
        #1;
        checks++;
        if (bus.DB_out !== 8'h5A || bus.DB_drv !== 1'b1) begin
            errors++; $display("FAIL db_pcl got=%h/%b exp=5A/1", bus.DB_out, bus.DB_drv);
        end
        bus.PCH_DB = 1'b1;
        #1;
        checks++;
        if (bus.DB_out !== 8'h00) begin errors++; $display("FAIL db_both got=%h exp=00", bus.DB_out); end
        bus.PCL_DB = 1'b0;
        #1;
        checks++;
        if (bus.DB_out !== 8'hA5) begin errors++; $display("FAIL db_pch got=%h exp=A5", bus.DB_out); end
        bus.PCH_DB  = 1'b0;
        bus.PCL_ADL = 1'b1;
        bus.PCH_ADH = 1'b1;
        #1;
        checks++;
        if ({bus.ADL_out, bus.ADL_drv, bus.ADH_out, bus.ADH_drv} !== {8'h5A, 1'b1, 8'hA5, 1'b1}) begin
            errors++; $display("FAIL addr_drive got=%h/%b %h/%b exp=5A/1 A5/1", bus.ADL_out, bus.ADL_drv, bus.ADH_out, bus.ADH_drv);
        end
        clear_strobes();
        #1;
        checks++;
        if ({bus.ADL_out, bus.ADH_out, bus.DB_out, bus.DB_drv} !== {8'hFF, 8'hFF, 8'hFF, 1'b0}) begin
            errors++; $display("FAIL bus_idle got=%h %h %h/%b exp=FF FF FF/0", bus.ADL_out, bus.ADH_out, bus.DB_out, bus.DB_drv);
        end
    endtask

    task automatic test_hold();
        load(8'h40, 8'h10);
        bus.n_IPC = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (bus.PC !== 16'h4011) begin errors++; $display("FAIL hold_inc[%0d] got=%h exp=4011", i, bus.PC); end
        end
        load(8'hFF, 8'h3C);
        bus.ADL_PCL = 1'b1;
        bus.PCL_PCL = 1'b1;
        bus.ADL_in  = 8'hF0;
        bus.DL_PCH  = 1'b1;
        bus.PCH_PCH = 1'b1;
        bus.DL_in   = 8'h0F;
        step();
        checks++;
        if (bus.PC !== 16'h0F30) begin errors++; $display("FAIL wired_and got=%h exp=0F30", bus.PC); end
        clear_strobes();
    endtask

    initial begin
        clear_strobes();
        test_reset();
        test_increment();
        test_jump();
        test_stall();
        test_bus();
        test_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
